// File: rtl/sd_block_responder.sv
// sd_block_responder
// Stands in for the SD card controller on its user-side block interface,
// serving 512-byte blocks out of on-chip block RAM with the controller's
// timing: an init delay, a command latency, paced byte handshakes and a
// programming delay after writes.
//
// Ports:
//   clk                  system clock
//   rst                  asynchronous active-low reset
//   address[31:0]        byte address; block index = address[9 +: log2(NUM_BLOCKS)]
//   ready                idle and accepting a request
//   rd / wr              read / write request, sampled while ready (rd wins)
//   dout[7:0]            read data byte
//   byte_available       high while a fresh dout byte is presented
//   din[7:0]             write data byte
//   ready_for_next_byte  one-cycle pulse requesting the next din byte
//   err                  sticky: an accepted request had address[8:0] != 0
module sd_block_responder #(
    parameter int NUM_BLOCKS  = 64,
    parameter int BYTE_PERIOD = 32,
    parameter int INIT_CYCLES = 64,
    parameter int CMD_CYCLES  = 16,
    parameter int PROG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    output logic        ready,
    input  logic        rd,
    output logic [7:0]  dout,
    output logic        byte_available,
    input  logic        wr,
    input  logic [7:0]  din,
    output logic        ready_for_next_byte,
    output logic        err
);

    localparam int BLK_W  = $clog2(NUM_BLOCKS);
    localparam int ADDR_W = BLK_W + 9;
    localparam int CNT_W  = 16;

    // A phase that starts on edge X with cnt_q cleared ends on edge X+N,
    // where cnt_q reads N-1.  INIT, CMD and PROG need one extra cycle
    // because their counting starts one edge before the phase they time.
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_CYCLES);
    localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BYTE_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BYTE_PERIOD - 2);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CMD, S_RD_HI, S_RD_LO, S_WR_REQ, S_WR_GAP, S_PROG
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [8:0]         k_q;
    logic [BLK_W-1:0]   blk_q;
    logic               is_rd_q;
    logic               ready_q;
    logic               ba_q;
    logic               rfnb_q;
    logic [7:0]         dout_q;
    logic               err_q;

    logic [7:0]         mem [NUM_BLOCKS*512];
    logic [7:0]         ram_q;
    logic [ADDR_W-1:0]  ram_raddr_d;
    logic               mem_we_d;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^address[31:9+BLK_W];

    // While a byte is low, fetch the next one so it is ready when RD_HI begins.
    always_comb begin
        ram_raddr_d = {blk_q, k_q};
        if (state_q == S_RD_LO) begin
            ram_raddr_d = {blk_q, k_q + 9'd1};
        end
    end

    // din is captured on the second edge after the pulse cycle.
    assign mem_we_d = (state_q == S_WR_GAP) && (cnt_q == '0);

    // Memory has no reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[{blk_q, k_q}] <= din;
        end
        ram_q <= mem[ram_raddr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            k_q     <= '0;
            blk_q   <= '0;
            is_rd_q <= 1'b0;
            ready_q <= 1'b0;
            ba_q    <= 1'b0;
            rfnb_q  <= 1'b0;
            dout_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                S_INIT: begin
                    if (cnt_q == INIT_LAST) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (rd || wr) begin
                        state_q <= S_CMD;
                        ready_q <= 1'b0;
                        is_rd_q <= rd;
                        blk_q   <= address[9 +: BLK_W];
                        k_q     <= '0;
                        cnt_q   <= '0;
                        if (address[8:0] != 9'd0) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    if (cnt_q == CMD_LAST) begin
                        cnt_q <= '0;
                        if (is_rd_q) begin
                            state_q <= S_RD_HI;
                            ba_q    <= 1'b1;
                            dout_q  <= ram_q;
                        end else begin
                            state_q <= S_WR_REQ;
                            rfnb_q  <= 1'b1;
                        end
                    end
                end
                S_RD_HI: begin
                    if (cnt_q == HALF_LAST) begin
                        state_q <= S_RD_LO;
                        ba_q    <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_RD_LO: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (k_q == 9'd511) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            k_q     <= k_q + 9'd1;
                            state_q <= S_RD_HI;
                            ba_q    <= 1'b1;
                            dout_q  <= ram_q;
                        end
                    end
                end
                S_WR_REQ: begin
                    state_q <= S_WR_GAP;
                    rfnb_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                S_WR_GAP: begin
                    // The programming delay is timed from the last data sample.
                    if ((cnt_q == '0) && (k_q == 9'd511)) begin
                        state_q <= S_PROG;
                        cnt_q   <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        k_q     <= k_q + 9'd1;
                        state_q <= S_WR_REQ;
                        rfnb_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_PROG: begin
                    if (cnt_q == PROG_LAST) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign ready               = ready_q;
    assign byte_available      = ba_q;
    assign ready_for_next_byte = rfnb_q;
    assign dout                = dout_q;
    assign err                 = err_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Testbench for sd_block_responder: table of whole-block transfers plus
// hand-written reset, init and abort-mid-write sequences.
module tb_sd_block_responder;

    localparam int NB   = 64;
    localparam int BP   = 16;
    localparam int INIT = 64;
    localparam int CMD  = 16;
    localparam int PROG = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = 32'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        ready;
    logic [7:0]  dout;
    logic        byte_available;
    logic        ready_for_next_byte;
    logic        err;

    int checks = 0;
    int errors = 0;

    sd_block_responder #(
        .NUM_BLOCKS (NB),
        .BYTE_PERIOD(BP),
        .INIT_CYCLES(INIT),
        .CMD_CYCLES (CMD),
        .PROG_CYCLES(PROG)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .address            (address),
        .ready              (ready),
        .rd                 (rd),
        .dout               (dout),
        .byte_available     (byte_available),
        .wr                 (wr),
        .din                (din),
        .ready_for_next_byte(ready_for_next_byte),
        .err                (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic        is_const;
        logic [7:0]  cval;
        logic        mid_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic is_const, input logic [7:0] cval, input int k);
        return is_const ? cval : 8'(k);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_byte_available"}, 32'(byte_available), 32'd0);
        check({tag, "_rfnb"}, 32'(ready_for_next_byte), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'h00);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < INIT + 100);
        check({tag, "_init_cycles"}, 32'(n), 32'(INIT + 1));
        $display("init %s: ready after %0d edges", tag, n);
    endtask

    // One block transfer. t counts edges after the accepting edge E.
    task automatic xfer(input string name, input logic req_rd, input logic req_wr,
                        input logic [31:0] addr, input logic is_const, input logic [7:0] cval,
                        input logic mid_rd, input int n_chk, input int abort_after);
        int   t, n_ba, n_rf, hi_len, tp, guard, t_ready;
        logic ba_prev;
        logic is_read;
        is_read = req_rd;
        guard = 0;
        while (!ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_ready_before"}, 32'(ready), 32'd1);
        rd = req_rd;
        wr = req_wr;
        address = addr;
        @(posedge clk); #1;
        rd = 1'b0;
        wr = 1'b0;
        address = 32'hFFFF_FFFF;
        check({name, "_accept_ready_low"}, 32'(ready), 32'd0);
        t = 0; n_ba = 0; n_rf = 0; hi_len = 0; tp = -10; ba_prev = 1'b0;
        t_ready = is_read ? (1 + CMD + 512 * BP) : (1 + CMD + 511 * BP + 2 + PROG + 1);
        while (t < t_ready + 40) begin
            @(posedge clk); #1;
            t++;
            rd = 1'b0;
            if (mid_rd && t == 1 + CMD + 100 * BP) rd = 1'b1;
            if (t == tp + 1) din = pat(is_const, cval, n_rf - 1);
            else if (t == tp + 2) din = ~pat(is_const, cval, n_rf - 1);
            if (ready_for_next_byte) begin
                check({name, "_pulse_time"}, 32'(t), 32'(1 + CMD + n_rf * BP));
                n_rf++;
                tp = t;
            end
            if (abort_after > 0 && n_rf == abort_after && t == tp + 4) begin
                #3 rst = 1'b0;
                #1 check_reset_outputs({name, "_async"});
                $display("xfer %s: reset after %0d bytes", name, n_rf);
                return;
            end
            if (byte_available && !ba_prev) begin
                check({name, "_ba_time"}, 32'(t), 32'(1 + CMD + n_ba * BP));
                if (n_ba < n_chk) check({name, "_data"}, 32'(dout), 32'(pat(is_const, cval, n_ba)));
                n_ba++;
                hi_len = 1;
            end else if (byte_available) begin
                hi_len++;
            end else if (ba_prev) begin
                check({name, "_ba_high_len"}, 32'(hi_len), 32'(BP / 2));
            end
            ba_prev = byte_available;
            if (ready) break;
        end
        check({name, "_ready_time"}, 32'(t), 32'(t_ready));
        check({name, "_n_byte_available"}, 32'(n_ba), is_read ? 32'd512 : 32'd0);
        check({name, "_n_rfnb"}, 32'(n_rf), is_read ? 32'd0 : 32'd512);
        $display("xfer %s: addr=%h bytes_rd=%0d bytes_wr=%0d ready_at=%0d err=%0b",
                 name, addr, n_ba, n_rf, t, err);
    endtask

    initial begin
        tbl[0] = '{"wr_blk2_ramp",     1'b0, 1'b1, 32'h0000_0400, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{"rd_wrap_blk2",     1'b1, 1'b0, 32'h0000_8400, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{"wr_misalign_a5",   1'b0, 1'b1, 32'h0000_0401, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{"rd_and_wr_midrd",  1'b1, 1'b1, 32'h0000_8400, 1'b1, 8'hA5, 1'b1, 1'b1};

        #2 rst = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_init("por");
        check("init_byte_available", 32'(byte_available), 32'd0);
        check("init_rfnb", 32'(ready_for_next_byte), 32'd0);
        check("init_dout", 32'(dout), 32'h00);
        check("init_err", 32'(err), 32'd0);

        for (int i = 0; i < 4; i++) begin
            xfer(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].is_const,
                 tbl[i].cval, tbl[i].mid_rd, 512, 0);
            check({tbl[i].name, "_err"}, 32'(err), 32'(tbl[i].exp_err));
        end

        // Reset partway through a write to block 3; bytes 0..99 must survive.
        xfer("wr_blk3_abort", 1'b0, 1'b1, 32'h0000_0600, 1'b0, 8'h00, 1'b0, 512, 100);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_init("after_abort");
        xfer("rd_blk3", 1'b1, 1'b0, 32'h0000_0600, 1'b0, 8'h00, 1'b0, 100, 0);
        check("rd_blk3_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
